hazard_unit: RTL and testbench
==============================

# hazard_unit

Hazard unit for the five-stage pipelined ARM datapath. It keeps a shadow pipeline of the register-read addresses and hazard-relevant control bits for the Execute, Memory and Writeback stages. From that pipeline it drives the datapath's stall, flush and forwarding selects. It sits beside the main controller and is clocked in lock-step with the datapath pipeline registers.

## Interface
Parameters:
- REG_AW, 4, register address width
- PC_REG, 4'd15, index of the PC register

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- ra1d  in  REG_AW  Decode read address 1 (after A1 mux)
- ra2d  in  REG_AW  Decode read address 2 (after A2 mux)
- wa3e, wa3m, wa3w  in  REG_AW  destination address in E/M/W
- RegWriteD, MemtoRegD, PCSrcD  in  1  Decode-stage control from decoder
- CondExE  in  1  condition passed in Execute
- BranchTakenE  in  1  branch resolved taken in Execute
- StallF, StallD, FlushD, FlushE  out  1  to datapath
- ForwardAE, ForwardBE  out  2  forward selects: 00 register file, 01 result_wire (W), 10 ALU result (M)
- stall_cnt, flush_cnt  out  32  performance counters (see Configuration)

## Operation
- Shadow E regs: ra1e, ra2e, RegWriteE, MemtoRegE, PCSrcE. They load the D inputs each cycle and are synchronously cleared when FlushE=1.
- Shadow M regs load from E: RegWriteM = RegWriteE & CondExE, PCSrcM = PCSrcE & CondExE. M has no flush.
- Shadow W regs load from M: RegWriteW, PCSrcW. W has no flush.
- Match_xE_M = (raxe==wa3m) & RegWriteM; Match_xE_W = (raxe==wa3w) & RegWriteW.
- ForwardxE: 10 if Match_xE_M, else 01 if Match_xE_W, else 00. M has priority over W.
- A match is never raised when raxe==PC_REG, because a PC read returns PC+8 from the register file.
- LDRstall = ((ra1d==wa3e)|(ra2d==wa3e)) & MemtoRegE & RegWriteE.
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- StallF = LDRstall | PCWrPendingF.
- StallD = LDRstall.
- FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
- FlushE = LDRstall | BranchTakenE.
- Simultaneous LDRstall and BranchTakenE: the flush wins. FlushE=1, FlushD=1, and StallD is still asserted, but the Decode register clears because flush dominates the enable.

## Timing
- Forward selects and stall/flush outputs are combinational from the shadow regs and the D-stage inputs, valid within the same cycle.
- Load-use: exactly one bubble. LDRstall is high for one cycle, then the dependent instruction forwards 01 from W.
- PC write via PCSrcD: FlushD stays high for 4 cycles (D, E, M, W), and StallF for 3 cycles.
- Taken branch: FlushD and FlushE are high for the one cycle where BranchTakenE=1.
- Reset (reset low): all shadow regs clear to 0 asynchronously. While reset is low, all outputs are forced to 0 (Forward = 00). After release, the first edge loads E from the D inputs.
- Reset asserted mid-operation discards all tracked hazards immediately.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments every cycle StallD=1.
  - flush_cnt increments every cycle FlushE=1.
  - Both counters clear to 0 on reset and saturate at 32'hFFFF_FFFF.
- HAZARD_PERF_CNT_EN undefined: both ports are tied to 32'd0 and no counter flops exist.

## Structure
- Package hazard_pkg holds:
  - localparams FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_AW
  - PC_REG
- Sub-module hazard_stage_reg: parameterised-width flop with async active-low reset and synchronous clear. It is used for the E, M and W shadow stages.

## Test plan
- Back-to-back ALU dependency: ADD R1 then SUB R2,R1,R3, with wa3m=1, RegWriteM=1, ra1e=1 → ForwardAE=10, ForwardBE=00.
- Dependency two apart with wa3w=1, RegWriteW=1, ra2e=1, no M match → ForwardBE=01. With an M match also present → 10.
- LDR R4 followed by ADD R5,R4,R4 → for one cycle: StallF=StallD=FlushE=1. Next cycle LDRstall=0 and ForwardAE=ForwardBE=01.
- Condition fails: RegWriteE=1, CondExE=0, wa3m=ra1e=6 → ForwardAE=00. A PCSrcE with failed condition → PCWrPendingF drops after E.
- PCSrcD pulse → FlushD high for 4 consecutive cycles, StallF for 3. Concurrent BranchTakenE=1 with LDRstall → FlushD=FlushE=1.
- ra1e=15 with wa3m=15, RegWriteM=1 → ForwardAE=00. With HAZARD_PERF_CNT_EN, after 3 load-use stalls → stall_cnt=3. Asserting reset mid-run clears the counters and forces all outputs to 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, PC index and forward-select encodings for the hazard unit.
package hazard_pkg;
    localparam int REG_AW = 4;
    localparam logic [REG_AW-1:0] PC_REG = 4'd15;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    function automatic logic [1:0] fwd_sel(input logic match_m, input logic match_w);
        return match_m ? FWD_MEM : match_w ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: shadow pipeline flop with async active-low reset and synchronous clear.
module hazard_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else q <= clr ? '0 : d;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the five-stage ARM pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_unit #(
    parameter int REG_AW = hazard_pkg::REG_AW,
    parameter logic [REG_AW-1:0] PC_REG = hazard_pkg::PC_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1d,
    input  logic [REG_AW-1:0] ra2d,
    input  logic [REG_AW-1:0] wa3e,
    input  logic [REG_AW-1:0] wa3m,
    input  logic [REG_AW-1:0] wa3w,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              PCSrcD,
    input  logic              CondExE,
    input  logic              BranchTakenE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);
    import hazard_pkg::*;
    logic [REG_AW-1:0] ra1e, ra2e;
    logic reg_write_e, mem_to_reg_e, pc_src_e;
    logic reg_write_m, pc_src_m, reg_write_w, pc_src_w;
    logic ldr_stall, pc_wr_pending;
    hazard_stage_reg #(.W(2 * REG_AW + 3)) u_stage_e (
        .clk   (clk),
        .rst_n (reset),
        .clr   (FlushE),
        .d     ({ra1d, ra2d, RegWriteD, MemtoRegD, PCSrcD}),
        .q     ({ra1e, ra2e, reg_write_e, mem_to_reg_e, pc_src_e})
    );
    hazard_stage_reg #(.W(2)) u_stage_m (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .d     ({reg_write_e & CondExE, pc_src_e & CondExE}),
        .q     ({reg_write_m, pc_src_m})
    );
    hazard_stage_reg #(.W(2)) u_stage_w (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .d     ({reg_write_m, pc_src_m}),
        .q     ({reg_write_w, pc_src_w})
    );
    // PC reads come from the register file as PC+8, so they never forward
    always_comb begin
        ldr_stall = ((ra1d == wa3e) | (ra2d == wa3e)) & mem_to_reg_e & reg_write_e;
        pc_wr_pending = PCSrcD | pc_src_e | pc_src_m;
        StallF = reset & (ldr_stall | pc_wr_pending);
        StallD = reset & ldr_stall;
        FlushD = reset & (pc_wr_pending | pc_src_w | BranchTakenE);
        FlushE = reset & (ldr_stall | BranchTakenE);
        ForwardAE = reset ? fwd_sel((ra1e != PC_REG) & (ra1e == wa3m) & reg_write_m,
                                    (ra1e != PC_REG) & (ra1e == wa3w) & reg_write_w) : FWD_RF;
        ForwardBE = reset ? fwd_sel((ra2e != PC_REG) & (ra2e == wa3m) & reg_write_m,
                                    (ra2e != PC_REG) & (ra2e == wa3w) & reg_write_w) : FWD_RF;
    end
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallD && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (FlushE && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit against an instruction-level pipeline model.
module tb_hazard_unit;
    import hazard_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] ra1d, ra2d, wa3e, wa3m, wa3w;
    logic RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE;
    logic StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] stall_cnt, flush_cnt;
    int n_cmp = 0;
    int n_err = 0;
    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic       rw;
        logic       mtr;
        logic       pcs;
    } instr_t;
    instr_t pe;
    logic m_rw, m_pcs, w_rw, w_pcs;
    int m_stalls, m_flushes;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .ra1d         (ra1d),
        .ra2d         (ra2d),
        .wa3e         (wa3e),
        .wa3m         (wa3m),
        .wa3w         (wa3w),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        pe = '0;
        m_rw = 0; m_pcs = 0; w_rw = 0; w_pcs = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
        if (!reset || ra == 4'd15) return FWD_RF;
        if (ra == wa3m && m_rw) return FWD_MEM;
        if (ra == wa3w && w_rw) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic bit ref_ldr();
        return (ra1d == wa3e || ra2d == wa3e) && pe.mtr && pe.rw;
    endfunction

    task automatic compare_all();
        bit ldr, pend;
        ldr = ref_ldr();
        pend = PCSrcD || pe.pcs || m_pcs;
        chk("StallF", StallF, reset && (ldr || pend));
        chk("StallD", StallD, reset && ldr);
        chk("FlushD", FlushD, reset && (pend || w_pcs || BranchTakenE));
        chk("FlushE", FlushE, reset && (ldr || BranchTakenE));
        chk("ForwardAE", ForwardAE, ref_fwd(pe.ra1));
        chk("ForwardBE", ForwardBE, ref_fwd(pe.ra2));
        chk("stall_cnt", stall_cnt, PERF ? m_stalls : 0);
        chk("flush_cnt", flush_cnt, PERF ? m_flushes : 0);
    endtask

    task automatic drive(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] we,
                         input logic [3:0] wm, input logic [3:0] ww, input logic rw,
                         input logic mtr, input logic pcs, input logic cond, input logic bt);
        ra1d = a1; ra2d = a2; wa3e = we; wa3m = wm; wa3w = ww;
        RegWriteD = rw; MemtoRegD = mtr; PCSrcD = pcs; CondExE = cond; BranchTakenE = bt;
        #1;
        compare_all();
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic tick();
        bit sd, fe;
        @(posedge clk);
        if (reset) begin
            sd = ref_ldr();
            fe = sd || BranchTakenE;
            if (sd) m_stalls++;
            if (fe) m_flushes++;
            w_rw = m_rw; w_pcs = m_pcs;
            m_rw = pe.rw & CondExE; m_pcs = pe.pcs & CondExE;
            pe = fe ? '0 : instr_t'({ra1d, ra2d, RegWriteD, MemtoRegD, PCSrcD});
        end
        #1;
    endtask

    task automatic load_use();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 1, 0); tick();
        drive(4, 4, 4, 0, 0, 1, 0, 0, 1, 0); tick();
        drive(4, 4, 0, 4, 0, 1, 0, 0, 1, 0); tick();
        nop(); tick();
    endtask

    function automatic logic [3:0] rnd_ra();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        model_clear();
        drive(4, 4, 4, 4, 4, 1, 1, 1, 1, 1);
        chk("rst_StallF", StallF, 0);
        chk("rst_FlushD", FlushD, 0);
        chk("rst_FlushE", FlushE, 0);
        tick(); tick();
        reset = 1'b1;
        nop();
        // back-to-back ALU dependency and two-apart dependency
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 0); tick();
        drive(1, 3, 1, 0, 0, 1, 0, 0, 1, 0); tick();
        drive(0, 1, 2, 1, 0, 0, 0, 0, 1, 0);
        chk("b2b_FAE", ForwardAE, 2'b10);
        chk("b2b_FBE", ForwardBE, 2'b00);
        tick();
        drive(0, 0, 0, 2, 1, 0, 0, 0, 1, 0);
        chk("two_FBE_wb", ForwardBE, 2'b01);
        chk("two_FAE", ForwardAE, 2'b00);
        drive(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        chk("two_FBE_mem", ForwardBE, 2'b10);
        tick();
        // load-use
        drive(0, 0, 0, 0, 0, 1, 1, 0, 1, 0); tick();
        drive(4, 4, 4, 0, 0, 1, 0, 0, 1, 0);
        chk("lu_StallF", StallF, 1);
        chk("lu_StallD", StallD, 1);
        chk("lu_FlushE", FlushE, 1);
        tick();
        drive(4, 4, 0, 4, 0, 1, 0, 0, 1, 0);
        chk("lu_nostall", StallD, 0);
        tick();
        drive(0, 0, 5, 0, 4, 0, 0, 0, 1, 0);
        chk("lu_FAE", ForwardAE, 2'b01);
        chk("lu_FBE", ForwardBE, 2'b01);
        tick();
        // failed condition
        drive(0, 0, 0, 0, 0, 1, 0, 1, 1, 0); tick();
        drive(6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("cf_StallF_E", StallF, 1);
        tick();
        drive(0, 0, 0, 6, 0, 0, 0, 0, 1, 0);
        chk("cf_FAE", ForwardAE, 2'b00);
        chk("cf_StallF_M", StallF, 0);
        tick();
        nop(); tick(); nop(); tick();
        // PC write pulse
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("pc_FlushD_0", FlushD, 1);
        chk("pc_StallF_0", StallF, 1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            nop();
            chk($sformatf("pc_FlushD_%0d", k), FlushD, k < 4);
            chk($sformatf("pc_StallF_%0d", k), StallF, k < 3);
            tick();
        end
        // taken branch concurrent with load-use
        drive(0, 0, 0, 0, 0, 1, 1, 0, 1, 0); tick();
        drive(4, 0, 4, 0, 0, 0, 0, 0, 1, 1);
        chk("br_FlushD", FlushD, 1);
        chk("br_FlushE", FlushE, 1);
        chk("br_StallD", StallD, 1);
        tick();
        // PC register never forwards
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 0); tick();
        drive(15, 15, 15, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 15, 0, 0, 0, 0, 1, 0);
        chk("pc_FAE", ForwardAE, 2'b00);
        chk("pc_FBE", ForwardBE, 2'b00);
        tick();
        // mid-run reset, then three load-use stalls
        reset = 1'b0;
        model_clear();
        drive(4, 4, 4, 15, 15, 1, 1, 1, 1, 1);
        chk("mr_StallF", StallF, 0);
        chk("mr_FlushD", FlushD, 0);
        tick();
        reset = 1'b1;
        load_use(); load_use(); load_use();
        chk("perf_stall3", stall_cnt, PERF ? 3 : 0);
        chk("perf_flush3", flush_cnt, PERF ? 3 : 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b0;
                model_clear();
            end
            drive(rnd_ra(), rnd_ra(), rnd_ra(), rnd_ra(), rnd_ra(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0);
            tick();
            reset = 1'b1;
        end
        reset = 1'b0;
        model_clear();
        nop();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
